uni2axi_burst: RTL and testbench
================================

// Module: uni2axi_burst
// PURPOSE
// Uni-bus to AXI4 master bridge, successor to the single-line bridge. Sits between the cache/uncached-LSU
// uni_if port and the SoC AXI4 crossbar. Generalised to any line/bus ratio and to 8-byte accesses.
// Latches each request at accept, so uni inputs may change once ready has pulsed. Adds a response-error report.
// PARAMETERS
// UNI_ADDR_WIDTH  32   uni address width
// UNI_DATA_WIDTH  128  uni line width; TRANS_LEN = UNI_DATA_WIDTH/AXI_DATA_WIDTH, power of 2, 1..256
// AXI_ADDR_WIDTH  32   AXI address width, >= UNI_ADDR_WIDTH (zero-extended)
// AXI_DATA_WIDTH  64   AXI data width, 32 or 64; OFF_W = clog2(AXI_DATA_WIDTH/8)
// AXI_ID_WIDTH    4    AXI id width; id driven 0
// AXI_USER_WIDTH  1    AXI user width; user driven 0
// PORTS
// i_clk      in   1  clock
// i_rst_n    in   1  asynchronous active-low reset
// UniIf_S    uni_if.Slave   valid,reqtyp,addr,size[1:0],cachable,wdata in; ready,rdata out
// AxiIf_M    axi4_if.Master all AW/W/B/AR/R channels
// o_bus_err  out  1  pulses with UniIf_S.ready when the transaction saw a non-OKAY resp
// BEHAVIOUR
// - One FSM: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, DONE. One transaction in flight; no concurrent R/W.
// - IDLE: when valid=1, latch addr/size/cachable/wdata/reqtyp. REQ_WRITE->WADDR, REQ_READ->RADDR.
// - WADDR: aw_valid=1; aw_hs->WDATA.  WDATA: w_valid=1; w_hs & w_last->WRESP.  WRESP: b_ready=1; b_hs->DONE.
// - RADDR: ar_valid=1; ar_hs->RDATA.  RDATA: r_ready=1; r_hs & r_last->DONE.
// - DONE: ready=1 for exactly one cycle, then IDLE. The earliest new accept is the cycle after DONE.
// - Latency: valid seen in IDLE -> aw/ar_valid the next cycle. ready is 1 cycle after the final b_hs/r_hs.
// - valid/ready of every AXI channel decode combinationally from state only; no dependence on the slave's ready.
// - Cachable: addr aligned down to UNI_DATA_WIDTH/8; len=TRANS_LEN-1; size=OFF_W; burst INCR; strb all 1.
// - Uncached: addr aligned down to AXI_DATA_WIDTH/8; off=addr[OFF_W-1:0]; len=0; size={1'b0,size}.
// - Uncached strb = ((1<<(1<<size))-1) << off. w_data = wdata[AXI_DATA_WIDTH-1:0] << (off*8).
// - size=3 with AXI_DATA_WIDTH=32 is illegal; an assertion flags it; behaviour is undefined.
// - Beat counter: OFF clog2(TRANS_LEN) bits (min 1). Clears on entry to WDATA/RDATA; +1 per w_hs/r_hs.
// - Beat counter saturates at len. w_data beat k = latched wdata[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH].
// - w_last = w_valid & (beat==len), combinational; independent of w_ready.
// - Read: beat k r_data -> rdata slot k. Uncached: slot 0 <= r_data >> (off*8).
// - rdata holds until the next read completes a beat; writes never modify it.
// - Early r_last (beat<len): transaction ends; remaining slots keep old data.
// - Extra beats after saturation (beat==len, no r_last) are accepted but not stored.
// - aw/ar prot = unprivileged|secure|data; cache/lock/qos/region = 0. b/r id ignored.
// - Reset: state=IDLE, beat=0, rdata=0, ready=0, o_bus_err=0, all AXI valid/ready=0 immediately (async).
// - Reset mid-burst abandons the transaction with no completion; the interconnect must be reset together.
// CONFIGURATION
// - UNI2AXI_RESP_CHK_EN defined: sticky err bit cleared on accept, set by b_hs with bresp!=0,
//   or by any r_hs with rresp!=0. o_bus_err = err in DONE, else 0.
// - Same macro defined: an error does not abort a burst; all beats are still consumed.
// - UNI2AXI_RESP_CHK_EN undefined: o_bus_err tied 0; resp fields ignored.
// TESTING
// - Cached read, 128/64, addr 0x8000_0018: ar_addr 0x8000_0010, len 1, size 3.
//   r_data A then B(last) -> rdata {B,A}, ready 1 cycle after B.
// - Uncached write, byte, addr 0x1000_0005, wdata 0x5A: strb 0x20, w_data 0x5A<<40, w_last on the 1st beat.
//   b_hs -> ready.
// - Uncached read, half, addr 0x2000_0006, r_data 0xBEEF_0000_0000_0000: rdata[15:0]=0xBEEF.
// - Backpressure: aw_ready low 5 cycles, w_ready toggling on a cached write.
//   Data beats stay stable until hs; exactly 2 w_hs; one ready.
// - Mid-RDATA async reset: all valids/readies 0 at once; after release IDLE; a new read completes normally.
// - With UNI2AXI_RESP_CHK_EN: rresp=SLVERR on beat 0 of 2 -> both beats consumed, o_bus_err=1 with ready.
//   The next OKAY read gives 0.

Source files
------------

// File: rtl/uni2axi_burst_if.sv
// Bus interfaces for the uni-bus to AXI4 burst bridge: the cache/LSU uni port and a full AXI4 port.
interface uni_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
) ();
    logic              valid;
    logic              reqtyp;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic              cachable;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic [DATA_W-1:0] rdata;

    modport Master (output valid, reqtyp, addr, size, cachable, wdata, input ready, rdata);
    modport Slave  (input valid, reqtyp, addr, size, cachable, wdata, output ready, rdata);
endinterface

interface axi4_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int USER_W = 1
) ();
    logic [ID_W-1:0]     aw_id;
    logic [ADDR_W-1:0]   aw_addr;
    logic [7:0]          aw_len;
    logic [2:0]          aw_size;
    logic [1:0]          aw_burst;
    logic                aw_lock;
    logic [3:0]          aw_cache;
    logic [2:0]          aw_prot;
    logic [3:0]          aw_qos;
    logic [3:0]          aw_region;
    logic [USER_W-1:0]   aw_user;
    logic                aw_valid;
    logic                aw_ready;
    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_last;
    logic [USER_W-1:0]   w_user;
    logic                w_valid;
    logic                w_ready;
    logic [ID_W-1:0]     b_id;
    logic [1:0]          b_resp;
    logic [USER_W-1:0]   b_user;
    logic                b_valid;
    logic                b_ready;
    logic [ID_W-1:0]     ar_id;
    logic [ADDR_W-1:0]   ar_addr;
    logic [7:0]          ar_len;
    logic [2:0]          ar_size;
    logic [1:0]          ar_burst;
    logic                ar_lock;
    logic [3:0]          ar_cache;
    logic [2:0]          ar_prot;
    logic [3:0]          ar_qos;
    logic [3:0]          ar_region;
    logic [USER_W-1:0]   ar_user;
    logic                ar_valid;
    logic                ar_ready;
    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_resp;
    logic                r_last;
    logic [USER_W-1:0]   r_user;
    logic                r_valid;
    logic                r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_region, aw_user, aw_valid, w_data, w_strb, w_last, w_user, w_valid, b_ready,
               ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_region, ar_user, ar_valid, r_ready,
        input  aw_ready, w_ready, b_id, b_resp, b_user, b_valid, ar_ready,
               r_id, r_data, r_resp, r_last, r_user, r_valid
    );
    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_region, aw_user, aw_valid, w_data, w_strb, w_last, w_user, w_valid, b_ready,
               ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_region, ar_user, ar_valid, r_ready,
        output aw_ready, w_ready, b_id, b_resp, b_user, b_valid, ar_ready,
               r_id, r_data, r_resp, r_last, r_user, r_valid
    );
endinterface

// File: rtl/uni2axi_burst.sv
// Uni-bus to AXI4 master bridge: one transaction in flight, line bursts or single uncached beats.
// Optional response-error reporting is enabled with the UNI2AXI_RESP_CHK_EN macro.
module uni2axi_burst_chk #(
    parameter int AXI_DATA_WIDTH = 64
) (
    input logic       clk,
    input logic       rst_n,
    input logic       accept,
    input logic       cachable,
    input logic [1:0] size
);
    // An 8-byte uncached access cannot be carried by a 32-bit data bus.
    a_size_fits_bus: assert property (@(posedge clk) disable iff (!rst_n)
        (accept && !cachable && (size == 2'd3)) |-> (AXI_DATA_WIDTH != 32));
endmodule

module uni2axi_burst #(
    parameter int UNI_ADDR_WIDTH = 32,
    parameter int UNI_DATA_WIDTH = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 1
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    uni_if.Slave  UniIf_S,
    axi4_if.Master AxiIf_M,
    output logic  o_bus_err
);
    localparam int TRANS_LEN  = UNI_DATA_WIDTH / AXI_DATA_WIDTH;
    localparam int OFF_W      = $clog2(AXI_DATA_WIDTH / 8);
    localparam int BEAT_W     = (TRANS_LEN > 1) ? $clog2(TRANS_LEN) : 1;
    localparam int STRB_W     = AXI_DATA_WIDTH / 8;
    localparam logic REQ_WRITE = 1'b1;
    localparam logic [AXI_ADDR_WIDTH-1:0] LINE_MASK = ~(AXI_ADDR_WIDTH'(UNI_DATA_WIDTH / 8 - 1));
    localparam logic [AXI_ADDR_WIDTH-1:0] WORD_MASK = ~(AXI_ADDR_WIDTH'(AXI_DATA_WIDTH / 8 - 1));

    typedef enum logic [2:0] {S_IDLE, S_WADDR, S_WDATA, S_WRESP, S_RADDR, S_RDATA, S_DONE} state_t;

    state_t                      state_r;
    logic [UNI_ADDR_WIDTH-1:0]   addr_r;
    logic [1:0]                  size_r;
    logic                        cach_r;
    logic [UNI_DATA_WIDTH-1:0]   wdata_r;
    logic [UNI_DATA_WIDTH-1:0]   rdata_r;
    logic [BEAT_W-1:0]           beat_r;
    logic                        sat_r;

    logic [AXI_ADDR_WIDTH-1:0]   ax_addr_s;
    logic [7:0]                  len_s;
    logic [2:0]                  ax_size_s;
    logic [OFF_W-1:0]            off_s;
    logic [7:0]                  byte_mask_s;
    logic [15:0]                 strb_wide_s;
    logic [STRB_W-1:0]           strb_s;
    logic [AXI_DATA_WIDTH-1:0]   w_data_s;
    logic [31:0]                 slot_base_s;
    logic                        last_beat_s;
    logic                        unused_ok_s;

    // Burst geometry from the latched request.
    always_comb begin
        off_s       = addr_r[OFF_W-1:0];
        slot_base_s = 32'(beat_r) * 32'(AXI_DATA_WIDTH);
        case (size_r)
            2'd0:    byte_mask_s = 8'h01;
            2'd1:    byte_mask_s = 8'h03;
            2'd2:    byte_mask_s = 8'h0F;
            2'd3:    byte_mask_s = 8'hFF;
            default: byte_mask_s = 8'h01;
        endcase
        strb_wide_s = {8'h00, byte_mask_s} << off_s;
        if (cach_r) begin
            ax_addr_s = AXI_ADDR_WIDTH'(addr_r) & LINE_MASK;
            len_s     = 8'(TRANS_LEN - 1);
            ax_size_s = 3'(OFF_W);
            strb_s    = {STRB_W{1'b1}};
            w_data_s  = wdata_r[slot_base_s +: AXI_DATA_WIDTH];
        end else begin
            ax_addr_s = AXI_ADDR_WIDTH'(addr_r) & WORD_MASK;
            len_s     = 8'd0;
            ax_size_s = {1'b0, size_r};
            strb_s    = strb_wide_s[STRB_W-1:0];
            w_data_s  = wdata_r[AXI_DATA_WIDTH-1:0] << {off_s, 3'b000};
        end
        last_beat_s = (8'(beat_r) == len_s);
    end

    assign AxiIf_M.aw_valid  = (state_r == S_WADDR);
    assign AxiIf_M.aw_id     = {AXI_ID_WIDTH{1'b0}};
    assign AxiIf_M.aw_addr   = ax_addr_s;
    assign AxiIf_M.aw_len    = len_s;
    assign AxiIf_M.aw_size   = ax_size_s;
    assign AxiIf_M.aw_burst  = 2'b01;
    assign AxiIf_M.aw_lock   = 1'b0;
    assign AxiIf_M.aw_cache  = 4'b0000;
    assign AxiIf_M.aw_prot   = 3'b000;
    assign AxiIf_M.aw_qos    = 4'b0000;
    assign AxiIf_M.aw_region = 4'b0000;
    assign AxiIf_M.aw_user   = {AXI_USER_WIDTH{1'b0}};
    assign AxiIf_M.w_valid   = (state_r == S_WDATA);
    assign AxiIf_M.w_data    = w_data_s;
    assign AxiIf_M.w_strb    = strb_s;
    assign AxiIf_M.w_last    = (state_r == S_WDATA) && last_beat_s;
    assign AxiIf_M.w_user    = {AXI_USER_WIDTH{1'b0}};
    assign AxiIf_M.b_ready   = (state_r == S_WRESP);
    assign AxiIf_M.ar_valid  = (state_r == S_RADDR);
    assign AxiIf_M.ar_id     = {AXI_ID_WIDTH{1'b0}};
    assign AxiIf_M.ar_addr   = ax_addr_s;
    assign AxiIf_M.ar_len    = len_s;
    assign AxiIf_M.ar_size   = ax_size_s;
    assign AxiIf_M.ar_burst  = 2'b01;
    assign AxiIf_M.ar_lock   = 1'b0;
    assign AxiIf_M.ar_cache  = 4'b0000;
    assign AxiIf_M.ar_prot   = 3'b000;
    assign AxiIf_M.ar_qos    = 4'b0000;
    assign AxiIf_M.ar_region = 4'b0000;
    assign AxiIf_M.ar_user   = {AXI_USER_WIDTH{1'b0}};
    assign AxiIf_M.r_ready   = (state_r == S_RDATA);
    assign UniIf_S.ready     = (state_r == S_DONE);
    assign UniIf_S.rdata     = rdata_r;

`ifdef UNI2AXI_RESP_CHK_EN
    logic err_r;
    assign o_bus_err   = (state_r == S_DONE) && err_r;
    assign unused_ok_s = ^{AxiIf_M.b_id, AxiIf_M.b_user, AxiIf_M.r_id, AxiIf_M.r_user};

    // Sticky response error for the transaction in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_r <= 1'b0;
        end else if ((state_r == S_IDLE) && UniIf_S.valid) begin
            err_r <= 1'b0;
        end else if ((state_r == S_WRESP) && AxiIf_M.b_valid && (AxiIf_M.b_resp != 2'b00)) begin
            err_r <= 1'b1;
        end else if ((state_r == S_RDATA) && AxiIf_M.r_valid && (AxiIf_M.r_resp != 2'b00)) begin
            err_r <= 1'b1;
        end
    end
`else
    assign o_bus_err   = 1'b0;
    assign unused_ok_s = ^{AxiIf_M.b_id, AxiIf_M.b_user, AxiIf_M.r_id, AxiIf_M.r_user,
                           AxiIf_M.b_resp, AxiIf_M.r_resp};
`endif

    // Transaction FSM with request latch, beat counter and read-line assembly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= S_IDLE;
            addr_r  <= {UNI_ADDR_WIDTH{1'b0}};
            size_r  <= 2'd0;
            cach_r  <= 1'b0;
            wdata_r <= {UNI_DATA_WIDTH{1'b0}};
            rdata_r <= {UNI_DATA_WIDTH{1'b0}};
            beat_r  <= {BEAT_W{1'b0}};
            sat_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: if (UniIf_S.valid) begin
                    addr_r  <= UniIf_S.addr;
                    size_r  <= UniIf_S.size;
                    cach_r  <= UniIf_S.cachable;
                    wdata_r <= UniIf_S.wdata;
                    state_r <= (UniIf_S.reqtyp == REQ_WRITE) ? S_WADDR : S_RADDR;
                end
                S_WADDR: if (AxiIf_M.aw_ready) begin
                    beat_r  <= {BEAT_W{1'b0}};
                    sat_r   <= 1'b0;
                    state_r <= S_WDATA;
                end
                S_WDATA: if (AxiIf_M.w_ready) begin
                    if (last_beat_s) state_r <= S_WRESP;
                    else             beat_r  <= beat_r + BEAT_W'(1'b1);
                end
                S_WRESP: if (AxiIf_M.b_valid) state_r <= S_DONE;
                S_RADDR: if (AxiIf_M.ar_ready) begin
                    beat_r  <= {BEAT_W{1'b0}};
                    sat_r   <= 1'b0;
                    state_r <= S_RDATA;
                end
                S_RDATA: if (AxiIf_M.r_valid) begin
                    // Beats beyond the burst length are consumed but dropped.
                    if (!sat_r) begin
                        if (cach_r) rdata_r[slot_base_s +: AXI_DATA_WIDTH] <= AxiIf_M.r_data;
                        else        rdata_r[AXI_DATA_WIDTH-1:0] <= AxiIf_M.r_data >> {off_s, 3'b000};
                    end
                    if (last_beat_s) sat_r  <= 1'b1;
                    else             beat_r <= beat_r + BEAT_W'(1'b1);
                    if (AxiIf_M.r_last) state_r <= S_DONE;
                end
                S_DONE:  state_r <= S_IDLE;
                default: state_r <= S_IDLE;
            endcase
        end
    end

    uni2axi_burst_chk #(.AXI_DATA_WIDTH(AXI_DATA_WIDTH)) u_chk (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .accept   ((state_r == S_IDLE) && UniIf_S.valid),
        .cachable (UniIf_S.cachable),
        .size     (UniIf_S.size)
    );
endmodule

// File: tb/tb_uni2axi_burst.sv
// Directed bench for uni2axi_burst (128-bit line, 64-bit AXI), acting as uni master and AXI slave.
module tb_uni2axi_burst;
    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    logic o_bus_err;
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic REQ_RD = 1'b0;
    localparam logic REQ_WR = 1'b1;
    localparam logic [63:0] DA = 64'hAAAA_0000_1111_2222;
    localparam logic [63:0] DB = 64'hBBBB_3333_4444_5555;
    localparam logic [63:0] DC = 64'hCCCC_9999_0000_1234;
    localparam logic [63:0] DD = 64'hDDDD_5678_9ABC_DEF0;
    localparam logic [63:0] DE = 64'hEEEE_6666_7777_8888;
    localparam logic [63:0] W0 = 64'h0D0D_1111_2222_3333;
    localparam logic [63:0] W1 = 64'h1D1D_4444_5555_6666;
`ifdef UNI2AXI_RESP_CHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    always #5 i_clk = ~i_clk;

    uni_if  #(.ADDR_W(32), .DATA_W(128)) uni ();
    axi4_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4), .USER_W(1)) axi ();

    uni2axi_burst #(
        .UNI_ADDR_WIDTH(32), .UNI_DATA_WIDTH(128), .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)
    ) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .UniIf_S   (uni),
        .AxiIf_M   (axi),
        .o_bus_err (o_bus_err)
    );

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic uni_req(input logic typ, input logic [31:0] a, input logic [1:0] sz,
                           input logic c, input logic [127:0] wd);
        uni.valid = 1'b1; uni.reqtyp = typ; uni.addr = a; uni.size = sz;
        uni.cachable = c; uni.wdata = wd;
        tick();
        // Scramble the request after accept; the bridge must use its latched copy.
        uni.valid = 1'b0; uni.reqtyp = ~typ; uni.addr = 32'hFFFF_FFFF; uni.size = ~sz;
        uni.cachable = ~c; uni.wdata = ~wd;
    endtask

    task automatic ar_accept(input string tag, input logic [31:0] a, input logic [7:0] len,
                             input logic [2:0] sz);
        check_vec({tag, ".ar_valid"}, axi.ar_valid, 1'b1);
        check_vec({tag, ".ar_addr"},  axi.ar_addr, a);
        check_vec({tag, ".ar_len"},   axi.ar_len, len);
        check_vec({tag, ".ar_size"},  axi.ar_size, sz);
        check_vec({tag, ".ar_burst"}, axi.ar_burst, 2'b01);
        axi.ar_ready = 1'b1;
        tick();
        axi.ar_ready = 1'b0;
    endtask

    task automatic aw_check(input string tag, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] sz);
        check_vec({tag, ".aw_valid"}, axi.aw_valid, 1'b1);
        check_vec({tag, ".aw_addr"},  axi.aw_addr, a);
        check_vec({tag, ".aw_len"},   axi.aw_len, len);
        check_vec({tag, ".aw_size"},  axi.aw_size, sz);
    endtask

    task automatic r_beat(input string tag, input logic [63:0] d, input logic last,
                          input logic [1:0] resp);
        check_vec({tag, ".r_ready"}, axi.r_ready, 1'b1);
        axi.r_valid = 1'b1; axi.r_data = d; axi.r_last = last; axi.r_resp = resp;
        tick();
        axi.r_valid = 1'b0; axi.r_last = 1'b0; axi.r_resp = 2'b00;
    endtask

    task automatic b_beat(input string tag, input logic [1:0] resp);
        check_vec({tag, ".b_ready"}, axi.b_ready, 1'b1);
        axi.b_valid = 1'b1; axi.b_resp = resp;
        tick();
        axi.b_valid = 1'b0; axi.b_resp = 2'b00;
    endtask

    task automatic expect_done(input string tag, input logic [127:0] rd, input logic err);
        check_vec({tag, ".ready"},   uni.ready, 1'b1);
        check_vec({tag, ".rdata"},   uni.rdata, rd);
        check_vec({tag, ".bus_err"}, o_bus_err, err);
        tick();
        check_vec({tag, ".ready_drop"}, uni.ready, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int hs;
        uni.valid = 1'b0; uni.reqtyp = 1'b0; uni.addr = 32'h0; uni.size = 2'd0;
        uni.cachable = 1'b0; uni.wdata = 128'h0;
        axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
        axi.b_valid = 1'b0; axi.b_resp = 2'b00; axi.b_id = 4'h0; axi.b_user = 1'b0;
        axi.r_valid = 1'b0; axi.r_data = 64'h0; axi.r_resp = 2'b00; axi.r_last = 1'b0;
        axi.r_id = 4'h0; axi.r_user = 1'b0;
        repeat (3) tick();
        check_vec("rst.ready",    uni.ready, 1'b0);
        check_vec("rst.aw_valid", axi.aw_valid, 1'b0);
        check_vec("rst.w_valid",  axi.w_valid, 1'b0);
        check_vec("rst.b_ready",  axi.b_ready, 1'b0);
        check_vec("rst.ar_valid", axi.ar_valid, 1'b0);
        check_vec("rst.r_ready",  axi.r_ready, 1'b0);
        check_vec("rst.rdata",    uni.rdata, 128'h0);
        check_vec("rst.bus_err",  o_bus_err, 1'b0);
        i_rst_n = 1'b1;
        tick();

        // Cached line read
        uni_req(REQ_RD, 32'h8000_0018, 2'd3, 1'b1, 128'h0);
        check_vec("crd.ar_prot",  axi.ar_prot, 3'b000);
        check_vec("crd.ar_cache", axi.ar_cache, 4'b0000);
        ar_accept("crd", 32'h8000_0010, 8'd1, 3'd3);
        r_beat("crd.b0", DA, 1'b0, 2'b00);
        check_vec("crd.no_early_ready", uni.ready, 1'b0);
        r_beat("crd.b1", DB, 1'b1, 2'b00);
        expect_done("crd", {DB, DA}, 1'b0);

        // Uncached byte write
        uni_req(REQ_WR, 32'h1000_0005, 2'd0, 1'b0, 128'h5A);
        aw_check("uwr", 32'h1000_0000, 8'd0, 3'd0);
        check_vec("uwr.aw_prot", axi.aw_prot, 3'b000);
        axi.aw_ready = 1'b1; tick(); axi.aw_ready = 1'b0;
        check_vec("uwr.w_valid", axi.w_valid, 1'b1);
        check_vec("uwr.w_strb",  axi.w_strb, 8'h20);
        check_vec("uwr.w_data",  axi.w_data, 64'h0000_5A00_0000_0000);
        check_vec("uwr.w_last",  axi.w_last, 1'b1);
        axi.w_ready = 1'b1; tick(); axi.w_ready = 1'b0;
        b_beat("uwr", 2'b00);
        expect_done("uwr", {DB, DA}, 1'b0);

        // Uncached half read at byte 6
        uni_req(REQ_RD, 32'h2000_0006, 2'd1, 1'b0, 128'h0);
        ar_accept("urd", 32'h2000_0000, 8'd0, 3'd1);
        r_beat("urd.b0", 64'hBEEF_0000_0000_0000, 1'b1, 2'b00);
        check_vec("urd.rdata16", uni.rdata[15:0], 16'hBEEF);
        expect_done("urd", {DB, 64'h0000_0000_0000_BEEF}, 1'b0);

        // Cached write under AW stall and toggling W ready
        uni_req(REQ_WR, 32'h3000_0008, 2'd3, 1'b1, {W1, W0});
        for (int i = 0; i < 5; i++) begin
            aw_check("bp", 32'h3000_0000, 8'd1, 3'd3);
            tick();
        end
        axi.aw_ready = 1'b1; tick(); axi.aw_ready = 1'b0;
        hs = 0;
        for (int c = 0; c < 12 && axi.w_valid; c++) begin
            axi.w_ready = c[0];
            check_vec("bp.w_data", axi.w_data, (hs == 0) ? W0 : W1);
            check_vec("bp.w_strb", axi.w_strb, 8'hFF);
            check_vec("bp.w_last", axi.w_last, (hs == 1));
            if (axi.w_ready) hs++;
            tick();
        end
        axi.w_ready = 1'b0;
        check_vec("bp.hs_count", hs, 2);
        check_vec("bp.b_wait", axi.b_ready, 1'b1);
        tick();
        check_vec("bp.no_ready", uni.ready, 1'b0);
        b_beat("bp", 2'b00);
        expect_done("bp", {DB, 64'h0000_0000_0000_BEEF}, 1'b0);
        tick();
        check_vec("bp.single_ready", uni.ready, 1'b0);

        // Early r_last leaves the upper slot untouched
        uni_req(REQ_RD, 32'h5000_0000, 2'd3, 1'b1, 128'h0);
        ar_accept("early", 32'h5000_0000, 8'd1, 3'd3);
        r_beat("early.b0", DE, 1'b1, 2'b00);
        expect_done("early", {DB, DE}, 1'b0);

        // Beats past the burst length are consumed but not stored
        uni_req(REQ_RD, 32'h5000_0010, 2'd3, 1'b1, 128'h0);
        ar_accept("extra", 32'h5000_0010, 8'd1, 3'd3);
        r_beat("extra.b0", DC, 1'b0, 2'b00);
        r_beat("extra.b1", DD, 1'b0, 2'b00);
        r_beat("extra.b2", DA, 1'b0, 2'b00);
        r_beat("extra.b3", DB, 1'b1, 2'b00);
        expect_done("extra", {DD, DC}, 1'b0);

        // Error responses do not cut the burst short
        uni_req(REQ_RD, 32'h6000_0000, 2'd3, 1'b1, 128'h0);
        ar_accept("rerr", 32'h6000_0000, 8'd1, 3'd3);
        r_beat("rerr.b0", DE, 1'b0, 2'b10);
        r_beat("rerr.b1", DA, 1'b1, 2'b00);
        expect_done("rerr", {DA, DE}, ERR_EXP);

        uni_req(REQ_WR, 32'h7000_0000, 2'd3, 1'b0, 128'h0123_4567_89AB_CDEF);
        aw_check("werr", 32'h7000_0000, 8'd0, 3'd3);
        axi.aw_ready = 1'b1; tick(); axi.aw_ready = 1'b0;
        check_vec("werr.w_strb", axi.w_strb, 8'hFF);
        check_vec("werr.w_data", axi.w_data, 64'h0123_4567_89AB_CDEF);
        axi.w_ready = 1'b1; tick(); axi.w_ready = 1'b0;
        b_beat("werr", 2'b10);
        expect_done("werr", {DA, DE}, ERR_EXP);

        uni_req(REQ_RD, 32'h6000_0004, 2'd2, 1'b0, 128'h0);
        ar_accept("rok", 32'h6000_0000, 8'd0, 3'd2);
        r_beat("rok.b0", 64'hCAFE_BABE_1234_5678, 1'b1, 2'b00);
        expect_done("rok", {DA, 64'h0000_0000_CAFE_BABE}, 1'b0);

        // Asynchronous reset in the middle of a read burst
        uni_req(REQ_RD, 32'h4000_0048, 2'd3, 1'b1, 128'h0);
        ar_accept("mrst", 32'h4000_0040, 8'd1, 3'd3);
        r_beat("mrst.b0", DC, 1'b0, 2'b00);
        #2 i_rst_n = 1'b0;
        #1;
        check_vec("mrst.r_ready",  axi.r_ready, 1'b0);
        check_vec("mrst.ar_valid", axi.ar_valid, 1'b0);
        check_vec("mrst.aw_valid", axi.aw_valid, 1'b0);
        check_vec("mrst.w_valid",  axi.w_valid, 1'b0);
        check_vec("mrst.b_ready",  axi.b_ready, 1'b0);
        check_vec("mrst.ready",    uni.ready, 1'b0);
        check_vec("mrst.rdata",    uni.rdata, 128'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        check_vec("mrst.idle_ready", uni.ready, 1'b0);
        check_vec("mrst.idle_ar",    axi.ar_valid, 1'b0);
        uni_req(REQ_RD, 32'h4000_0048, 2'd3, 1'b1, 128'h0);
        ar_accept("post", 32'h4000_0040, 8'd1, 3'd3);
        r_beat("post.b0", DB, 1'b0, 2'b00);
        r_beat("post.b1", DE, 1'b1, 2'b00);
        expect_done("post", {DE, DB}, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
